// File: rtl/display_scan_controller.sv
// Round-robin scan controller for DIGITS common-anode 7-segment digits sharing one decoder.
// Each digit slot is a BLANK gap (all digits off) followed by a SHOW window for that digit.
module display_scan_controller #(
   parameter int DIGITS       = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      wr_en,
   input  logic [$clog2(DIGITS)-1:0] wr_addr,
   input  logic [5:0]                wr_data,
   input  logic [DIGITS-1:0]         blink_mask,
   output logic [5:0]                char_code,
   output logic [DIGITS-1:0]         digit_n,
   output logic                      frame_done
);

   localparam int IW      = $clog2(DIGITS);
   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int FW      = $clog2(BLINK_FRAMES + 1);
   localparam logic [5:0] BLANK_CODE = 6'h3F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic            blink_q, blink_d;
   logic [5:0]      buf_q [DIGITS];
   logic [5:0]      buf_d [DIGITS];
   logic            frame_end;
   logic [5:0]      char_d;
   logic [DIGITS-1:0] digit_d;
   logic [DIGITS-1:0] digit_sel;

   // State register: FSM, counters, character buffer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         frame_q    <= '0;
         blink_q    <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            buf_q[i] <= BLANK_CODE;
         end
         char_code  <= BLANK_CODE;
         digit_n    <= '1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         frame_q    <= frame_d;
         blink_q    <= blink_d;
         for (int i = 0; i < DIGITS; i++) begin
            buf_q[i] <= buf_d[i];
         end
         char_code  <= char_d;
         digit_n    <= digit_d;
         frame_done <= frame_end;
      end
   end

   // Addresses at or beyond DIGITS match no entry, so such writes fall through.
   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         buf_d[i] = buf_q[i];
         if (wr_en && (wr_addr == IW'(i))) begin
            buf_d[i] = wr_data;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      frame_d   = frame_q;
      blink_d   = blink_q;
      frame_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = BLANK;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         BLANK: begin
            if (!enable) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               frame_d = '0;
            end else if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
               state_d = SHOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SHOW: begin
            if (!enable) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               frame_d = '0;
            end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
               state_d = BLANK;
               cnt_d   = '0;
               if (idx_q == IW'(DIGITS - 1)) begin
                  idx_d     = '0;
                  frame_end = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            frame_d = '0;
         end
      endcase
      // Blink phase flips after BLINK_FRAMES completed frames; aborts never reach here.
      if (frame_end) begin
         if (frame_q == FW'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + FW'(1);
         end
      end
   end

   // Outputs are computed from next-state values so the registered pins line up with
   // the state they describe; a buffer write shows on char_code one cycle later.
   always_comb begin
      char_d    = BLANK_CODE;
      digit_d   = '1;
      digit_sel = DIGITS'(1) << idx_d;
      case (state_d)
         BLANK: begin
            char_d = (blink_mask[idx_d] && blink_d) ? BLANK_CODE : buf_d[idx_d];
         end
         SHOW: begin
            char_d  = (blink_mask[idx_d] && blink_d) ? BLANK_CODE : buf_d[idx_d];
            digit_d = ~digit_sel;
         end
         default: begin
            char_d  = BLANK_CODE;
            digit_d = '1;
         end
      endcase
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller: 4-digit instance for the scan/blink/abort
// behaviour and a 5-digit instance for out-of-range write addresses.
module tb_display_scan_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [5:0] wr_data = '0;
   logic [3:0] blink_mask = '0;
   logic [5:0] char_code;
   logic [3:0] digit_n;
   logic       frame_done;

   logic       enable5 = 1'b0;
   logic       wr_en5 = 1'b0;
   logic [2:0] wr_addr5 = '0;
   logic [5:0] wr_data5 = '0;
   logic [4:0] blink_mask5 = '0;
   logic [5:0] char_code5;
   logic [4:0] digit_n5;
   logic       frame_done5;

   int n_checks = 0;
   int n_pass = 0;
   int k = -1;
   int mode = 0;        // 0: main idle, 1: main scanning, 2: second instance phase
   bit active5 = 1'b0;
   int phase_base = 0;
   logic [5:0] exp_buf [4];
   logic [5:0] buf5 [5];

   always #5 clk = ~clk;

   display_scan_controller #(
      .DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
   ) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .blink_mask(blink_mask), .char_code(char_code),
      .digit_n(digit_n), .frame_done(frame_done)
   );

   display_scan_controller #(
      .DIGITS(5), .SCAN_DIV(1), .BLANK_CYCLES(1), .BLINK_FRAMES(1)
   ) u_dut5 (
      .clk(clk), .rst(rst), .enable(enable5), .wr_en(wr_en5), .wr_addr(wr_addr5),
      .wr_data(wr_data5), .blink_mask(blink_mask5), .char_code(char_code5),
      .digit_n(digit_n5), .frame_done(frame_done5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
      end
   endtask

   // Expected main-instance outputs come from the slot arithmetic: slot = 6 cycles
   // (2 blank + 4 show), frame = 24 cycles, blink half-period = 48 cycles.
   task automatic check_main_active();
      int slot, pos, ph;
      logic [3:0] sel, e_dn;
      logic [5:0] e_cc;
      slot = (k % 24) / 6;
      pos  = k % 6;
      ph   = ((k / 48) + phase_base) % 2;
      sel  = 4'b0001 << slot;
      e_dn = (pos >= 2) ? ~sel : 4'hF;
      e_cc = (blink_mask[slot] && (ph == 1)) ? 6'h3F : exp_buf[slot];
      check("digit_n", digit_n, e_dn);
      check("char_code", char_code, e_cc);
      check("frame_done", frame_done, (k > 0 && (k % 24) == 0) ? 1 : 0);
   endtask

   // Second instance: slot = 2 cycles (1 blank + 1 show), frame = 10 cycles.
   task automatic check_five_active();
      int slot;
      logic [4:0] sel, e_dn;
      slot = (k % 10) / 2;
      sel  = 5'b00001 << slot;
      e_dn = ((k % 2) == 1) ? ~sel : 5'h1F;
      check("digit_n5", digit_n5, e_dn);
      check("char_code5", char_code5, buf5[slot]);
      check("frame_done5", frame_done5, (k == 10) ? 1 : 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      k++;
      @(negedge clk);
      check("onehot", ($countones(~digit_n) <= 1) ? 1 : 0, 1);
      check("onehot5", ($countones(~digit_n5) <= 1) ? 1 : 0, 1);
      if (mode == 1) begin
         check_main_active();
      end else begin
         check("idle_digit_n", digit_n, 4'hF);
         check("idle_char_code", char_code, 6'h3F);
         check("idle_frame_done", frame_done, 0);
      end
      if (mode == 2) begin
         if (active5) begin
            check_five_active();
         end else begin
            check("idle_digit_n5", digit_n5, 5'h1F);
            check("idle_char_code5", char_code5, 6'h3F);
         end
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [5:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      exp_buf[a] = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic wr5(input logic [2:0] a, input logic [5:0] d);
      wr_en5 = 1'b1;
      wr_addr5 = a;
      wr_data5 = d;
      if (a < 3'd5) buf5[a] = d;
      cyc();
      wr_en5 = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) exp_buf[i] = 6'h3F;
      for (int i = 0; i < 5; i++) buf5[i] = 6'h3F;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_digit_n", digit_n, 4'hF);
      check("rst_char_code", char_code, 6'h3F);
      check("rst_frame_done", frame_done, 0);
      check("rst_digit_n5", digit_n5, 5'h1F);
      rst = 1'b0;
      cyc();
      cyc();

      // Blank buffer: one full frame plus part of the next, all codes 3F
      enable = 1'b1;
      mode = 1;
      k = -1;
      while (k < 39) cyc();

      // Asynchronous reset while SHOW of idx 2 (k=39 -> slot 2, pos 3)
      #1 rst = 1'b1;
      #1;
      check("rst_mid_digit_n", digit_n, 4'hF);
      check("rst_mid_char_code", char_code, 6'h3F);
      check("rst_mid_frame_done", frame_done, 0);
      @(negedge clk);
      rst = 1'b0;
      k = -1;
      while (k < 7) cyc();
      enable = 1'b0;
      mode = 0;
      cyc();
      cyc();

      // Fill the buffer while idle, then scan with digit 1 blinking
      wr(2'd0, 6'd1);
      wr(2'd1, 6'd2);
      wr(2'd2, 6'd3);
      wr(2'd3, 6'd4);
      blink_mask = 4'b0010;
      enable = 1'b1;
      mode = 1;
      phase_base = 0;
      k = -1;
      while (k < 191) begin
         if (k == 98) wr(2'd0, 6'h0A);   // digit 0 is in SHOW at k=98
         else cyc();
      end

      // Abort on the last SHOW cycle of idx 3: no frame_done, phase held at 1
      enable = 1'b0;
      mode = 0;
      cyc();
      cyc();
      enable = 1'b1;
      mode = 1;
      phase_base = 1;
      k = -1;
      while (k < 60) cyc();
      enable = 1'b0;
      mode = 0;
      cyc();

      // Out-of-range writes on the 5-digit instance are ignored
      mode = 2;
      active5 = 1'b0;
      wr5(3'd5, 6'd1);
      wr5(3'd6, 6'd2);
      wr5(3'd7, 6'd3);
      wr5(3'd4, 6'd4);
      wr5(3'd1, 6'd9);
      enable5 = 1'b1;
      active5 = 1'b1;
      k = -1;
      while (k < 12) cyc();
      enable5 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
